// File: rtl/layer_vec_feeder.sv
// Streams an N-element input vector into a layer and captures its M-element result vector.
// Optional ReLU result check is compiled in with `define LAYER_VEC_FEEDER_RELU_CHK_EN.
module layer_vec_feeder #(
    parameter int M = 8,
    parameter int N = 4,
    parameter int T = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_en,
    input  logic [$clog2(N)-1:0] ld_addr,
    input  logic signed [T-1:0]  ld_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [T-1:0]  m_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [T-1:0]  s_data,
    input  logic [$clog2(M)-1:0] rd_addr,
    output logic signed [T-1:0]  rd_data,
    output logic                 err
);
    localparam int XAW = $clog2(N);
    localparam int YAW = $clog2(M);
    localparam int SW  = $clog2(N + 1);
    localparam int RW  = $clog2(M + 1);

    // valid/ready: a beat moves on a rising edge where valid && ready; the
    // sender holds data stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SW-1:0]       send_cnt;
    logic [RW-1:0]       recv_cnt;
    logic signed [T-1:0] xbuf [N];
    logic signed [T-1:0] ybuf [M];
    logic                start_ok;
    logic                send_beat;
    logic                recv_beat;

    assign start_ok  = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign m_valid   = (state == SEND);
    assign s_ready   = (state == RECV);
    assign send_beat = m_valid && m_ready;
    assign recv_beat = s_valid && s_ready;
    assign m_data    = xbuf[send_cnt[XAW-1:0]];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: if (send_beat && send_cnt == SW'(N - 1)) state_nxt = RECV;
            RECV: if (recv_beat && recv_cnt == RW'(M - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            send_cnt <= '0;
            recv_cnt <= '0;
        end else if (start_ok) begin
            send_cnt <= '0;
            recv_cnt <= '0;
        end else begin
            if (send_beat) send_cnt <= send_cnt + 1'b1;
            if (recv_beat) recv_cnt <= recv_cnt + 1'b1;
        end
    end

    // Buffers hold data across reset; only the host side or a live run may write them.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && ld_en) xbuf[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && recv_beat) ybuf[recv_cnt[YAW-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= ybuf[rd_addr];
    end

`ifdef LAYER_VEC_FEEDER_RELU_CHK_EN
    // A negative result cannot come out of a ReLU layer; flag it until the next run.
    always_ff @(posedge clk) begin
        if (reset)                          err <= 1'b0;
        else if (start_ok)                  err <= 1'b0;
        else if (recv_beat && s_data[T-1])  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_vec_feeder.sv
// Randomized bench for layer_vec_feeder: a small layer model drives both streams and a
// vector-level model predicts the send order, captured results, handshakes and err.
module tb_layer_vec_feeder;
    localparam int M   = 8;
    localparam int N   = 4;
    localparam int T   = 16;
    localparam int XAW = $clog2(N);
    localparam int YAW = $clog2(M);
`ifdef LAYER_VEC_FEEDER_RELU_CHK_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ld_en;
    logic [XAW-1:0]       ld_addr;
    logic signed [T-1:0]  ld_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [T-1:0]  m_data;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [T-1:0]  s_data;
    logic [YAW-1:0]       rd_addr;
    logic signed [T-1:0]  rd_data;
    logic                 err;

    layer_vec_feeder #(.M(M), .N(N), .T(T)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [T-1:0] x_model [N];
    logic [T-1:0] y_model [M];
    logic [T-1:0] res_vals [M];
    logic [T-1:0] exp_q [$];
    logic         err_exp;
    int           rpat [7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic check(input string tag, input logic [T-1:0] got, input logic [T-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_x();
        for (int i = 0; i < N; i++) begin
            ld_en   = 1'b1;
            ld_addr = XAW'(i);
            ld_data = x_model[i];
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic read_back();
        for (int i = 0; i < M; i++) begin
            rd_addr = YAW'(i);
            tick();
            check("rd_data", rd_data, y_model[i]);
        end
    endtask

    // rmode: 0 always ready, 1 fixed toggle pattern, 2 random
    // vmode: 0 always valid, 1 every 3rd cycle, 2 random
    task automatic run(input int rmode, input int vmode, input bit inject, input int abort_at,
                       input bit check_len, input bit ld_with_start);
        int  sent = 0;
        int  recv = 0;
        bit  finished = 0;
        bit  xfer;
        if (ld_with_start) begin
            x_model[N-1] = T'($urandom_range(0, 65535));
            ld_en   = 1'b1;
            ld_addr = XAW'(N - 1);
            ld_data = x_model[N-1];
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(x_model[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        err_exp = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            check("busy", T'(busy), T'(1'b1));
            check("m_valid", T'(m_valid), T'(sent < N));
            check("s_ready", T'(s_ready), T'(sent == N && recv < M));
            check("done", T'(done), T'(recv == M));
            check("err", T'(err), T'(err_exp));
            if (sent < N) check("m_data", m_data, exp_q[0]);
            if (recv == M) begin
                if (check_len) check("run_len", T'(cyc), T'(N + M));
                finished = 1;
                break;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = rpat[cyc % 7] != 0;
                default: m_ready = $urandom_range(0, 1) != 0;
            endcase
            if (inject && cyc < 2) m_ready = 1'b0;
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 3) == 2;
                default: s_valid = $urandom_range(0, 1) != 0;
            endcase
            s_data = res_vals[recv];
            if (inject && cyc == 1) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_addr = '0;
                ld_data = 16'sd99;
            end
            xfer = (sent < N) && m_ready;
            if (xfer) begin
                void'(exp_q.pop_front());
                sent++;
            end else if (sent == N && s_valid) begin
                y_model[recv] = res_vals[recv];
                if (res_vals[recv][T-1]) err_exp = RELU;
                recv++;
            end
            tick();
            start = 1'b0;
            ld_en = 1'b0;
            if (abort_at > 0 && recv == abort_at) begin
                reset   = 1'b1;
                s_valid = 1'b0;
                m_ready = 1'b0;
                tick();
                reset = 1'b0;
                check("rst_busy", T'(busy), '0);
                check("rst_s_ready", T'(s_ready), '0);
                check("rst_m_valid", T'(m_valid), '0);
                check("rst_done", T'(done), '0);
                check("rst_err", T'(err), '0);
                return;
            end
        end
        if (!finished) check("timeout", '0, T'(1));
        m_ready = 1'b0;
        s_valid = 1'b0;
        tick();
        check("post_busy", T'(busy), '0);
        check("post_done", T'(done), '0);
        check("post_err", T'(err), T'(err_exp));
    endtask

    task automatic rand_x();
        for (int i = 0; i < N; i++) x_model[i] = T'($urandom_range(0, 65535));
    endtask

    task automatic rand_res(input bit allow_neg);
        for (int i = 0; i < M; i++)
            res_vals[i] = allow_neg ? T'($urandom_range(0, 65535)) : T'($urandom_range(0, 32767));
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        m_ready = 1'b0; s_valid = 1'b0; s_data = '0; rd_addr = '0;
        tick();
        tick();
        check("reset_busy", T'(busy), '0);
        check("reset_done", T'(done), '0);
        check("reset_m_valid", T'(m_valid), '0);
        check("reset_s_ready", T'(s_ready), '0);
        check("reset_rd_data", rd_data, '0);
        check("reset_err", T'(err), '0);
        reset = 1'b0;
        tick();

        // basic run
        for (int i = 0; i < N; i++) x_model[i] = T'(i + 1);
        for (int i = 0; i < M; i++) res_vals[i] = T'(10 * (i + 1));
        load_x();
        run(0, 0, 0, 0, 1, 0);
        read_back();

        // backpressure with boundary values
        x_model[0] = -16'sd5; x_model[1] = 16'sd7; x_model[2] = 16'sd0; x_model[3] = 16'sd32767;
        load_x();
        rand_res(0);
        run(1, 0, 0, 0, 0, 0);
        read_back();

        // sparse results, then stray s_valid in IDLE
        rand_res(0);
        run(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = T'($urandom_range(0, 65535));
            check("idle_s_ready", T'(s_ready), '0);
            tick();
        end
        s_valid = 1'b0;
        read_back();

        // start and ld_en mid-SEND are ignored
        rand_res(0);
        run(0, 0, 1, 0, 0, 0);
        rand_res(0);
        run(0, 0, 0, 0, 0, 0);
        read_back();

        // negative result at index 4
        for (int i = 0; i < M; i++) res_vals[i] = T'(i + 1);
        res_vals[4] = -16'sd3;
        run(0, 0, 0, 0, 0, 0);
        read_back();
        rand_res(0);
        run(0, 0, 0, 0, 0, 0);

        // reset mid-RECV, then a full run
        rand_res(0);
        run(0, 0, 0, 3, 0, 0);
        rand_res(0);
        run(0, 0, 0, 0, 1, 0);
        read_back();

        // random runs, some loading with start in the same cycle
        for (int r = 0; r < 6; r++) begin
            rand_x();
            load_x();
            rand_res(1);
            run(2, 2, 0, 0, 0, r % 2 == 1);
            read_back();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/layer_vec_feeder.md
Name: layer_vec_feeder

Overview:
- Stream master/slave harness that drives one vector-input layer and collects its result vector.
- Holds an N-entry input vector loaded by the host and streams it to the layer's input (valid/ready, one T-bit element per beat).
- Accepts M T-bit results from the layer's output stream into a result buffer, then signals done.
- Sits between host/testbench control and a layer instance: `m_*` connects to the layer's `s_valid`/`s_ready`/`data_in`; `s_*` connects to the layer's `m_valid`/`m_ready`/`data_out`.

Parameters:
- M, 8: number of result elements received per run.
- N, 4: number of input elements sent per run.
- T, 16: element width, signed two's complement.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- ld_en  input  1  host write strobe into the input buffer.
- ld_addr  input  $clog2(N)  input buffer write address.
- ld_data  input  T  input buffer write data (signed).
- start  input  1  one-cycle pulse; begins a run.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when all M results are stored.
- m_valid  output  1  input element valid toward the layer.
- m_ready  input  1  layer ready to accept an element.
- m_data  output  T  current input element (signed).
- s_valid  input  1  layer result valid.
- s_ready  output  1  feeder ready to accept a result.
- s_data  input  T  layer result (signed).
- rd_addr  input  $clog2(M)  result buffer read address.
- rd_data  output  T  result buffer read data; registered, 1-cycle latency.
- err  output  1  sticky result-check flag (see Optional Feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset state: FSM=IDLE; send_cnt=0; recv_cnt=0.
- Reset values of outputs: busy=0, done=0, m_valid=0, s_ready=0, rd_data=0, err=0.
- Buffer contents are not reset.
- FSM states: IDLE, SEND, RECV, DONE.
- IDLE:
  - ld_en writes ld_data to xbuf[ld_addr].
  - start moves to SEND, clears send_cnt and recv_cnt, and clears err.
- SEND:
  - m_valid=1; m_data=xbuf[send_cnt] (combinational from the register array).
  - A beat transfers when m_valid&&m_ready; send_cnt then increments.
  - The transfer with send_cnt==N-1 moves to RECV; m_valid is 0 the following cycle.
  - m_data must be held stable while m_valid=1 and m_ready=0.
- RECV:
  - s_ready=1.
  - Each s_valid&&s_ready writes s_data to ybuf[recv_cnt] and increments recv_cnt.
  - The beat with recv_cnt==M-1 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SEND, RECV and DONE.
- Counter widths are $clog2(N+1) and $clog2(M+1); no wrap beyond N-1 / M-1.
- s_valid in IDLE or SEND: ignored, s_ready=0, no write.
- ld_en while busy: ignored; the buffer is frozen during a run.
- start while busy: ignored.
- start and ld_en in the same IDLE cycle: the write completes, and SEND uses the new value.
- rd_data=ybuf[rd_addr] registered every cycle in all states. A read of the address being written returns the old value.
- Reset mid-run: returns to IDLE on the next edge; all outputs take their reset values; partial results stay in ybuf but are not valid.
- Minimum run length with always-ready partners: 1 (start) + N + M + 1 cycles.

Optional Feature:
- Macro: LAYER_VEC_FEEDER_RELU_CHK_EN.
- Defined:
  - Every accepted result with s_data[T-1]==1 (negative, illegal after ReLU) sets err.
  - err is sticky until reset or the next accepted start.
  - The negative value is still stored unmodified.
- Undefined: no check logic; err tied 0.

Test Plan:
- Basic run: load xbuf={1,2,3,4}; start; layer model always ready and returns 10,20,...,80 after the last input. Required: m_data sequence 1,2,3,4; ybuf[0..7]=10..80; done pulses once; busy drops with done.
- Backpressure: m_ready toggled 1,0,0,1,0,1,1 during SEND with xbuf={-5,7,0,32767}. Required: each element is held stable while stalled; exactly 4 transfers in order; no duplicates.
- Sparse results: s_valid asserted every 3rd cycle. Required: exactly M=8 captures; DONE only after the 8th; extra s_valid pulses in IDLE are not stored and do not change ybuf.
- Ignored events: start and ld_en (addr 0, data 99) pulsed mid-SEND. Required: no restart; xbuf[0] still sends its original value; busy stays high.
- Reset mid-RECV after 3 results. Required: next cycle busy=0, s_ready=0, m_valid=0, done=0; a new start runs a full correct cycle.
- With LAYER_VEC_FEEDER_RELU_CHK_EN: result 4 = -16'd3. Required: err=1 from the cycle after capture through done; cleared by the next start. Without the macro: err stays 0.
